machine_fifo: RTL

- Host-facing FIFO pair that sits at the other end of a state machine's push/pull interface.
- TX FIFO: the host writes words; the machine pulls them via `din`/`empty`.
- RX FIFO: the machine pushes words via `dout`/`full`; the host reads them.
- Supports joining both storage banks into one deeper FIFO in either direction, restart flush, and sticky overflow/stall flags.

---
 rtl/machine_fifo_pkg.sv | 13 +
 rtl/machine_fifo_core.sv | 69 ++++++
 rtl/machine_fifo.sv | 111 +++++++++++
 3 files changed

// File: rtl/machine_fifo_pkg.sv
// Shared constants for the machine-facing FIFO pair: default geometry and
// the bit positions of the sticky error flags.
package machine_fifo_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_WIDTH = 32;

    localparam int FLAG_TX_OVER  = 0;
    localparam int FLAG_TX_STALL = 1;
    localparam int FLAG_RX_STALL = 2;
    localparam int FLAG_RX_UNDER = 3;

endpackage

// File: rtl/machine_fifo_core.sv
// Single FWFT FIFO with 2*DEPTH words of storage and a runtime capacity of
// 0, DEPTH or 2*DEPTH; status depends only on the registered pointers.
module fifo_core #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(2 * DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [CW-1:0]    cap,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    level
);

    logic [WIDTH-1:0] mem [2*DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    mask;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             wr_en;
    logic             rd_en;

    // Pointers run freely over CW bits; capacity is a power of two dividing
    // 2^CW, so masking the low bits gives the slot and the top bit acts as wrap.
    assign level  = wr_ptr_q - rd_ptr_q;
    assign empty  = (level == '0);
    assign full   = (level == cap);
    assign mask   = AW'(cap - 1'b1);
    assign wr_idx = wr_ptr_q[AW-1:0] & mask;
    assign rd_idx = rd_ptr_q[AW-1:0] & mask;
    assign wr_en  = wr && !full;
    assign rd_en  = rd && !empty;
    assign rdata  = empty ? '0 : mem[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/machine_fifo.sv
// Host-side TX/RX FIFO pair for a push/pull state machine, with bank joining,
// restart flush and sticky write-1-to-clear error flags.
module machine_fifo
    import machine_fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    parameter  int WIDTH = FIFO_WIDTH,
    localparam int LW    = $clog2(2 * DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             join_tx,
    input  logic             join_rx,
    input  logic             tx_wr,
    input  logic [WIDTH-1:0] tx_wdata,
    output logic             tx_full,
    output logic [LW-1:0]    tx_level,
    input  logic             pull,
    output logic [WIDTH-1:0] din,
    output logic             empty,
    input  logic             push,
    input  logic [WIDTH-1:0] dout,
    output logic             full,
    input  logic             rx_rd,
    output logic [WIDTH-1:0] rx_rdata,
    output logic             rx_empty,
    output logic [LW-1:0]    rx_level,
    input  logic [3:0]       flag_clr,
    output logic [3:0]       flags
);

    logic          join_tx_q, join_tx_d;
    logic          join_rx_q, join_rx_d;
    logic [3:0]    flags_q, flags_d;
    logic [3:0]    flag_set;
    logic [LW-1:0] tx_cap;
    logic [LW-1:0] rx_cap;
    logic          flush;

    // Capacity follows the registered join mode so full/empty never see a
    // same-cycle input; a mode change flushes on the edge it is registered.
    always_comb begin
        tx_cap = LW'(DEPTH);
        rx_cap = LW'(DEPTH);
        if (join_tx_q) begin
            tx_cap = LW'(2 * DEPTH);
            rx_cap = '0;
        end else if (join_rx_q) begin
            tx_cap = '0;
            rx_cap = LW'(2 * DEPTH);
        end
    end

    assign flush = restart || (join_tx != join_tx_q) || (join_rx != join_rx_q);

    always_comb begin
        join_tx_d = join_tx;
        join_rx_d = join_rx;
        flag_set  = '0;
        flag_set[FLAG_TX_OVER]  = tx_wr && tx_full;
        flag_set[FLAG_TX_STALL] = pull && empty;
        flag_set[FLAG_RX_STALL] = push && full;
        flag_set[FLAG_RX_UNDER] = rx_rd && rx_empty;
        flags_d = (flags_q & ~flag_clr) | flag_set;
        if (restart) flags_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            join_tx_q <= 1'b0;
            join_rx_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            join_tx_q <= join_tx_d;
            join_rx_q <= join_rx_d;
            flags_q   <= flags_d;
        end
    end

    assign flags = flags_q;

    fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .cap     (tx_cap),
        .wr      (tx_wr),
        .wdata   (tx_wdata),
        .rd      (pull),
        .rdata   (din),
        .empty   (empty),
        .full    (tx_full),
        .level   (tx_level)
    );

    fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .cap     (rx_cap),
        .wr      (push),
        .wdata   (dout),
        .rd      (rx_rd),
        .rdata   (rx_rdata),
        .empty   (rx_empty),
        .full    (full),
        .level   (rx_level)
    );

endmodule
